// File: rtl/microseq_control_unit.sv
// ---------------------------------------------------------------------------
// microseq_control_unit
//   Hardwired multi-cycle control sequencer for the mini-SRC datapath.
//   Fetches in T0..T2, decodes the IR opcode and emits per-step datapath
//   control for each instruction class. Memory steps (Read / ramWE) stall
//   on mem_ready; a stall of TIMEOUT consecutive cycles halts the sequencer
//   and latches mem_err. HALT is left only through clr.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   run        in   permits starting a new instruction
//   ir         in   instruction register contents (opcode in the top OPW bits)
//   mem_ready  in   memory done for the current Read/ramWE step
//   ctrl       out  28-bit datapath control vector (Moore decode)
//   step       out  current T index, 0 when IDLE or HALT
//   busy       out  high in T0..T7
//   instr_done out  high during the final (advancing) cycle of an instruction
//   halted     out  high in HALT
//   mem_err    out  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module microseq_control_unit #(
    parameter int IR_W    = 32,
    parameter int OPW     = 5,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_ready,
    output logic [27:0]     ctrl,
    output logic [2:0]      step,
    output logic            busy,
    output logic            instr_done,
    output logic            halted,
    output logic            mem_err
);

    // ctrl bit positions
    localparam int B_PCOUT    = 0;
    localparam int B_PCIN     = 1;
    localparam int B_INCPC    = 2;
    localparam int B_MARIN    = 3;
    localparam int B_MDRIN    = 4;
    localparam int B_MDROUT   = 5;
    localparam int B_READ     = 6;
    localparam int B_RAMWE    = 7;
    localparam int B_IRIN     = 8;
    localparam int B_YIN      = 9;
    localparam int B_ZLOWIN   = 10;
    localparam int B_ZHIGHIN  = 11;
    localparam int B_ZLOWOUT  = 12;
    localparam int B_ZHIGHOUT = 13;
    localparam int B_HIIN     = 14;
    localparam int B_LOIN     = 15;
    localparam int B_HIOUT    = 16;
    localparam int B_LOOUT    = 17;
    localparam int B_GRA      = 18;
    localparam int B_GRB      = 19;
    localparam int B_GRC      = 20;
    localparam int B_RIN      = 21;
    localparam int B_ROUT     = 22;
    localparam int B_BAOUT    = 23;
    localparam int B_COUT     = 24;
    localparam int B_INPORT   = 25;
    localparam int B_OUTPORT  = 26;

    // Counter only has to reach TIMEOUT-1 before the halting edge.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU3, C_ALUI, C_MULDIV,
        C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            err_q, err_d;

    logic [OPW-1:0]  opcode;
    int unsigned     opv;
    cls_e            cls;
    logic [2:0]      last_t;
    logic            is_last;
    logic            mem_wait;
    logic            timeout_hit;
    logic            unused_ir;

    assign opcode    = ir[IR_W-1 -: OPW];
    assign unused_ir = ^ir[IR_W-OPW-1:0];

    // Opcode class decode
    always_comb begin
        opv = 32'(opcode);
        cls = C_NOP;
        if (opv == 0)                   cls = C_LD;
        else if (opv == 1)              cls = C_LDI;
        else if (opv == 2)              cls = C_ST;
        else if (opv inside {[3:11]})   cls = C_ALU3;
        else if (opv inside {[12:14]})  cls = C_ALUI;
        else if (opv inside {[15:16]})  cls = C_MULDIV;
        else if (opv == 22)             cls = C_IN;
        else if (opv == 23)             cls = C_OUT;
        else if (opv == 24)             cls = C_MFHI;
        else if (opv == 25)             cls = C_MFLO;
        else if (opv == 27)             cls = C_HALT;
    end

    // Final T-step of each class
    always_comb begin
        unique case (cls)
            C_LD, C_ST:              last_t = 3'd7;
            C_MULDIV:                last_t = 3'd6;
            C_LDI, C_ALU3, C_ALUI:   last_t = 3'd5;
            C_IN, C_OUT, C_MFHI,
            C_MFLO:                  last_t = 3'd3;
            default:                 last_t = 3'd2;
        endcase
    end

    // Status outputs derived from registered state
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign step    = busy ? 3'(state_q - S_T0) : 3'd0;
    assign mem_err = err_q;

    // Moore control decode: registered state plus opcode
    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_T0: begin
                ctrl[B_PCOUT] = 1'b1; ctrl[B_MARIN]  = 1'b1;
                ctrl[B_INCPC] = 1'b1; ctrl[B_ZLOWIN] = 1'b1;
            end
            S_T1: begin
                ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_PCIN]  = 1'b1;
                ctrl[B_READ]    = 1'b1; ctrl[B_MDRIN] = 1'b1;
            end
            S_T2: begin
                ctrl[B_MDROUT] = 1'b1; ctrl[B_IRIN] = 1'b1;
            end
            S_T3: begin
                unique case (cls)
                    C_LD, C_LDI, C_ST: begin
                        ctrl[B_GRB] = 1'b1; ctrl[B_BAOUT] = 1'b1; ctrl[B_YIN] = 1'b1;
                    end
                    C_ALU3, C_ALUI: begin
                        ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_YIN] = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_YIN] = 1'b1;
                    end
                    C_IN: begin
                        ctrl[B_INPORT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                    end
                    C_OUT: begin
                        ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_OUTPORT] = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl[B_HIOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                    end
                    C_MFLO: begin
                        ctrl[B_LOOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                unique case (cls)
                    C_LD, C_LDI, C_ST, C_ALUI: begin
                        ctrl[B_COUT] = 1'b1;
                        ctrl[B_ZLOWIN] = 1'b1; ctrl[B_ZHIGHIN] = 1'b1;
                    end
                    C_ALU3: begin
                        ctrl[B_GRC] = 1'b1; ctrl[B_ROUT] = 1'b1;
                        ctrl[B_ZLOWIN] = 1'b1; ctrl[B_ZHIGHIN] = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl[B_GRB] = 1'b1; ctrl[B_ROUT] = 1'b1;
                        ctrl[B_ZLOWIN] = 1'b1; ctrl[B_ZHIGHIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                unique case (cls)
                    C_LD, C_ST: begin
                        ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_MARIN] = 1'b1;
                    end
                    C_LDI, C_ALU3, C_ALUI: begin
                        ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl[B_ZLOWOUT] = 1'b1; ctrl[B_LOIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                unique case (cls)
                    C_LD: begin
                        ctrl[B_READ] = 1'b1; ctrl[B_MDRIN] = 1'b1;
                    end
                    C_ST: begin
                        ctrl[B_GRA] = 1'b1; ctrl[B_ROUT] = 1'b1; ctrl[B_MDRIN] = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl[B_ZHIGHOUT] = 1'b1; ctrl[B_HIIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                unique case (cls)
                    C_LD: begin
                        ctrl[B_MDROUT] = 1'b1; ctrl[B_GRA] = 1'b1; ctrl[B_RIN] = 1'b1;
                    end
                    C_ST: begin
                        ctrl[B_MDROUT] = 1'b1; ctrl[B_RAMWE] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // A memory step is recognised from its own control word, so any step
    // driving Read or ramWE stalls on mem_ready.
    assign mem_wait    = busy && (ctrl[B_READ] || ctrl[B_RAMWE]) && !mem_ready;
    assign timeout_hit = mem_wait && (TIMEOUT != 0) && (wcnt_q == CW'(TIMEOUT - 1));
    assign is_last     = busy && (step == last_t);
    assign instr_done  = is_last && !mem_wait;

    always_comb begin
        state_d = state_q;
        wcnt_d  = '0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_HALT: ;
            default: begin
                if (mem_wait) begin
                    if (timeout_hit) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else if (is_last) begin
                    if (cls == C_HALT) state_d = S_HALT;
                    else               state_d = run ? S_T0 : S_IDLE;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

endmodule
